// File: rtl/mem_responder_pkg.sv
// Shared types and sizes for the mem_responder slice.
package mem_responder_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: load, saturating decrement, zero / last-step flags.
module mem_wait_counter
    import mem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c,
    output logic             o_last_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);
    assign o_last_c = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_responder.sv
// Single-port 32x8 memory responder with programmable wait states.
// Optional parity storage/checking enabled by MEM_RESPONDER_PARITY_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
`ifdef MEM_RESPONDER_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    req_t              r_cap;
    req_t              w_op;
    logic              w_load;
    logic              w_dec;
    logic              w_zero;
    logic              w_last;
    logic              w_commit;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (CNT_W'(WAIT_CYCLES)),
        .i_dec      (w_dec),
        .o_zero_c   (w_zero),
        .o_last_c   (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_load = 1'b1;
                    w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_dec = 1'b1;
                if (w_last || w_zero) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the capture edge, so use live inputs.
    assign w_op     = (r_state == ST_IDLE) ? req_t'({we, addr, wdata}) : r_cap;
    assign w_commit = (w_next == ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_commit;
            if (w_load) begin
                r_cap <= req_t'({we, addr, wdata});
            end
            if (w_commit && !w_op.we) begin
                r_rdata <= r_mem[w_op.addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_op.we) begin
            r_mem[w_op.addr] <= w_op.wdata;
        end
    end

`ifdef MEM_RESPONDER_PARITY_EN
    logic r_par [DEPTH];
    logic r_parity_err;

    // Parity bit travels with each word; mismatch is flagged alongside rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
            r_parity_err <= 1'b0;
        end else if (w_commit) begin
            if (w_op.we) begin
                r_par[w_op.addr] <= even_parity(w_op.wdata);
            end else begin
                r_parity_err <= (even_parity(r_mem[w_op.addr]) != r_par[w_op.addr]);
            end
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_CYCLES=2 and 0 instances).
// Parity scenario is compiled only with MEM_RESPONDER_PARITY_EN.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] addr = '0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic [4:0] addr0 = '0;
    logic       req0 = 1'b0;
    logic       we0 = 1'b0;
    logic [7:0] wdata0 = '0;
    logic [7:0] rdata0;
    logic       ack0;
    logic       busy0;
`ifdef MEM_RESPONDER_PARITY_EN
    logic       perr;
    logic       perr0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .req        (req),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
`ifdef MEM_RESPONDER_PARITY_EN
        .parity_err (perr),
`endif
        .busy       (busy)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr0),
        .req        (req0),
        .we         (we0),
        .wdata      (wdata0),
        .rdata      (rdata0),
        .ack        (ack0),
`ifdef MEM_RESPONDER_PARITY_EN
        .parity_err (perr0),
`endif
        .busy       (busy0)
    );

    // One transaction on the WAIT_CYCLES=2 instance; observes a fixed 6-cycle window.
    task automatic run_txn(input logic t_we, input logic [4:0] t_addr, input logic [7:0] t_wdata,
                           output int ack_at, output int ack_cnt, output int busy_cnt,
                           output logic [7:0] got);
        ack_at   = -1;
        ack_cnt  = 0;
        busy_cnt = 0;
        got      = 8'hxx;
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) req = 1'b0;
            if (busy) busy_cnt++;
            if (ack) begin
                ack_cnt++;
                if (ack_at < 0) begin
                    ack_at = k;
                    got    = rdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks += 5;
        if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", rdata); end
        if (ack !== 1'b0)    begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
        if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (rdata0 !== 8'h00) begin failures++; $display("FAIL reset_rdata0 got=%h want=00", rdata0); end
        if (busy0 !== 1'b0)  begin failures++; $display("FAIL reset_busy0 got=%b want=0", busy0); end
        rst = 1'b0;
    endtask

    task automatic test_read_latency();
        int a_at, a_cnt, b_cnt;
        logic [7:0] g;
        run_txn(1'b0, 5'd3, 8'h00, a_at, a_cnt, b_cnt, g);
        checks += 4;
        if (a_at !== 2)   begin failures++; $display("FAIL rd_latency got=%0d want=2", a_at); end
        if (a_cnt !== 1)  begin failures++; $display("FAIL rd_ack_count got=%0d want=1", a_cnt); end
        if (b_cnt !== 3)  begin failures++; $display("FAIL rd_busy_cycles got=%0d want=3", b_cnt); end
        if (g !== 8'h00)  begin failures++; $display("FAIL rd_reset_data got=%h want=00", g); end
    endtask

    task automatic test_write_read();
        int a_at, a_cnt, b_cnt;
        logic [7:0] g;
        run_txn(1'b1, 5'd31, 8'hA5, a_at, a_cnt, b_cnt, g);
        checks += 3;
        if (a_at !== 2)  begin failures++; $display("FAIL wr_latency got=%0d want=2", a_at); end
        if (b_cnt !== 3) begin failures++; $display("FAIL wr_busy_cycles got=%0d want=3", b_cnt); end
        if (rdata !== 8'h00) begin failures++; $display("FAIL wr_rdata_kept got=%h want=00", rdata); end
        run_txn(1'b0, 5'd31, 8'h00, a_at, a_cnt, b_cnt, g);
        checks += 3;
        if (g !== 8'hA5) begin failures++; $display("FAIL wr_rd_data got=%h want=a5", g); end
        if (b_cnt !== 3) begin failures++; $display("FAIL wr_rd_busy_cycles got=%0d want=3", b_cnt); end
        if (a_cnt !== 1) begin failures++; $display("FAIL wr_rd_ack_count got=%0d want=1", a_cnt); end
    endtask

    task automatic test_frozen_capture();
        int a_at, a_cnt, b_cnt;
        logic [7:0] g;
        logic [7:0] eb;
        logic [7:0] ea;
        eb = 8'b0111_0111;
        ea = 8'b0100_0100;
        run_txn(1'b1, 5'd4, 8'h11, a_at, a_cnt, b_cnt, g);
        run_txn(1'b1, 5'd7, 8'h5A, a_at, a_cnt, b_cnt, g);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 5'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks += 2;
            if (busy !== eb[k]) begin failures++; $display("FAIL frz_busy[%0d] got=%b want=%b", k, busy, eb[k]); end
            if (ack !== ea[k])  begin failures++; $display("FAIL frz_ack[%0d] got=%b want=%b", k, ack, ea[k]); end
            if (k == 0) addr = 5'd7;
            if (k == 2) begin
                checks++;
                if (rdata !== 8'h11) begin failures++; $display("FAIL frz_rdata_first got=%h want=11", rdata); end
            end
            if (k == 4) req = 1'b0;
            if (k == 6) begin
                checks++;
                if (rdata !== 8'h5A) begin failures++; $display("FAIL frz_rdata_second got=%h want=5a", rdata); end
            end
        end
        run_txn(1'b1, 5'd9, 8'h77, a_at, a_cnt, b_cnt, g);
        checks++;
        if (rdata !== 8'h5A) begin failures++; $display("FAIL write_keeps_rdata got=%h want=5a", rdata); end
    endtask

    task automatic test_back_to_back_wait0();
        logic       wes [4];
        logic [7:0] wds [4];
        int idx;
        wes[0] = 1'b1; wds[0] = 8'h3C;
        wes[1] = 1'b0; wds[1] = 8'h3C;
        wes[2] = 1'b1; wds[2] = 8'hC3;
        wes[3] = 1'b0; wds[3] = 8'hC3;
        idx = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = wes[0]; wdata0 = wds[0]; addr0 = 5'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks += 2;
            if (ack0 !== ((k % 2) == 0))  begin failures++; $display("FAIL w0_ack[%0d] got=%b want=%b", k, ack0, (k % 2) == 0); end
            if (busy0 !== ((k % 2) == 0)) begin failures++; $display("FAIL w0_busy[%0d] got=%b want=%b", k, busy0, (k % 2) == 0); end
            if ((k % 2) == 0) begin
                if (!wes[idx]) begin
                    checks++;
                    if (rdata0 !== wds[idx]) begin failures++; $display("FAIL w0_rdata[%0d] got=%h want=%h", idx, rdata0, wds[idx]); end
                end
                idx++;
                if (idx < 4) begin
                    we0 = wes[idx]; wdata0 = wds[idx];
                end else begin
                    req0 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int a_at, a_cnt;
        logic [7:0] g;
        a_at = -1; a_cnt = 0; g = 8'hxx;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 5'd1; wdata = 8'hFF;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b want=1", busy); end
        #2 rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_rst got=%b want=0", busy); end
        if (ack !== 1'b0)  begin failures++; $display("FAIL abort_ack_rst got=%b want=0", ack); end
        @(negedge clk);
        rst = 1'b0;
        req = 1'b1; we = 1'b0; addr = 5'd1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req = 1'b0;
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL first_edge_capture got=%b want=1", busy); end
            end
            if (ack) begin
                a_cnt++;
                if (a_at < 0) begin a_at = k; g = rdata; end
            end
        end
        checks += 3;
        if (a_at !== 2)  begin failures++; $display("FAIL abort_rd_latency got=%0d want=2", a_at); end
        if (a_cnt !== 1) begin failures++; $display("FAIL abort_ack_count got=%0d want=1", a_cnt); end
        if (g !== 8'h00) begin failures++; $display("FAIL abort_no_write got=%h want=00", g); end
    endtask

`ifdef MEM_RESPONDER_PARITY_EN
    task automatic test_parity();
        int a_at, a_cnt, b_cnt;
        logic [7:0] g;
        run_txn(1'b1, 5'd2, 8'h0F, a_at, a_cnt, b_cnt, g);
        run_txn(1'b0, 5'd2, 8'h00, a_at, a_cnt, b_cnt, g);
        checks++;
        if (perr !== 1'b0) begin failures++; $display("FAIL par_clean got=%b want=0", perr); end
        dut.r_mem[2] = dut.r_mem[2] ^ 8'h01;
        run_txn(1'b0, 5'd2, 8'h00, a_at, a_cnt, b_cnt, g);
        checks += 2;
        if (g !== 8'h0E)   begin failures++; $display("FAIL par_flip_data got=%h want=0e", g); end
        if (perr !== 1'b1) begin failures++; $display("FAIL par_flip_err got=%b want=1", perr); end
        run_txn(1'b0, 5'd3, 8'h00, a_at, a_cnt, b_cnt, g);
        checks++;
        if (perr !== 1'b0) begin failures++; $display("FAIL par_cleared got=%b want=0", perr); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_frozen_capture();
        test_back_to_back_wait0();
        test_reset_abort();
`ifdef MEM_RESPONDER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
